// File: rtl/rounding_pkg.sv
// Shared FP rounding definitions: rounding modes, status layout and divider constants.
// The divider FSM states live here too so the datapath and its round stage agree.
package rounding_pkg;

    typedef enum logic [2:0] {
        IEEE_near = 3'd0,
        IEEE_zero = 3'd1,
        IEEE_pinf = 3'd2,
        IEEE_ninf = 3'd3,
        near_up   = 3'd4,
        away_zero = 3'd5
    } round_mode_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        DIV   = 3'd2,
        ROUND = 3'd3,
        DONE  = 3'd4
    } div_state_t;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;
    localparam int QBITS = 25;

    localparam logic [4:0]  CNT_INIT = 5'(QBITS - 1);
    localparam logic [31:0] QNAN     = 32'h7FC00000;
    localparam logic [30:0] MAXF_MAG = 31'h7F7FFFFF;

    localparam int ST_ZERO    = 0;
    localparam int ST_INF     = 1;
    localparam int ST_NAN     = 2;
    localparam int ST_TINY    = 3;
    localparam int ST_HUGE    = 4;
    localparam int ST_INEXACT = 5;
    localparam int ST_DIVZERO = 7;

endpackage

// File: rtl/fp_div_round.sv
// Final rounding of the restoring-division quotient, including overflow to
// inf/max-finite and flush-to-zero (or min-normal) underflow.
module fp_div_round
    import rounding_pkg::*;
(
    input  logic              i_sign,
    input  logic signed [9:0] i_exp,
    input  logic [QBITS-1:0]  i_q,
    input  logic              i_sticky,
    input  logic [2:0]        i_mode,
    output logic [31:0]       o_z,
    output logic [7:0]        o_status
);
    logic              w_guard, w_lsb, w_inexact, w_up, w_away, w_toward;
    logic [24:0]       w_sum;
    logic signed [9:0] w_exp;

    assign w_guard   = i_q[0];
    assign w_lsb     = i_q[1];
    assign w_inexact = w_guard | i_sticky;
    assign w_away    = (i_mode == away_zero) || (i_mode == IEEE_pinf && !i_sign) ||
                       (i_mode == IEEE_ninf && i_sign);
    assign w_toward  = (i_mode == IEEE_zero) || (i_mode == IEEE_pinf && i_sign) ||
                       (i_mode == IEEE_ninf && !i_sign);

    // Round-up decision per mode; unused codes fall back to nearest-even
    always_comb begin
        w_up = 1'b0;
        case (i_mode)
            IEEE_near: w_up = w_guard & (i_sticky | w_lsb);
            IEEE_zero: w_up = 1'b0;
            IEEE_pinf: w_up = w_inexact & ~i_sign;
            IEEE_ninf: w_up = w_inexact & i_sign;
            near_up:   w_up = (w_guard & ~i_sign) | (w_guard & i_sticky);
            away_zero: w_up = w_inexact;
            default:   w_up = w_guard & (i_sticky | w_lsb);
        endcase
    end

    // A carry out of the significand leaves the stored mantissa bits at zero
    assign w_sum = {1'b0, i_q[QBITS-1:1]} + {24'd0, w_up};
    assign w_exp = w_sum[24] ? (i_exp + 10'sd1) : i_exp;

    // Range handling on the rounded exponent
    always_comb begin
        o_z                  = {i_sign, w_exp[7:0], w_sum[22:0]};
        o_status             = 8'd0;
        o_status[ST_INEXACT] = w_inexact;
        if (w_exp >= 10'sd255) begin
            o_status[ST_HUGE]    = 1'b1;
            o_status[ST_INEXACT] = 1'b1;
            if (w_toward) begin
                o_z = {i_sign, MAXF_MAG};
            end else begin
                o_z              = {i_sign, 8'hFF, 23'd0};
                o_status[ST_INF] = 1'b1;
            end
        end else if (w_exp <= 10'sd0) begin
            o_status[ST_TINY]    = 1'b1;
            o_status[ST_INEXACT] = 1'b1;
            if (w_away) begin
                o_z = {i_sign, 8'h01, 23'd0};
            end else begin
                o_z               = {i_sign, 31'd0};
                o_status[ST_ZERO] = 1'b1;
            end
        end else begin
            o_z = {i_sign, w_exp[7:0], w_sum[22:0]};
        end
    end

endmodule

// File: rtl/fp_div.sv
// Iterative binary32 divider: radix-2 restoring division, one quotient bit per
// cycle, behind a start/busy/done handshake. Denormal inputs read as zero.
module fp_div
    import rounding_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  rnd,
    output logic        busy,
    output logic        done,
    output logic [31:0] z,
    output logic [7:0]  status
);
    div_state_t        r_state, w_next;
    logic [31:0]       r_a, r_b, r_z;
    logic [2:0]        r_rnd;
    logic              r_sign, r_busy, r_done;
    logic signed [9:0] r_exp;
    logic [25:0]       r_rem;
    logic [23:0]       r_div;
    logic [QBITS-1:0]  r_q;
    logic [4:0]        r_cnt;
    logic [7:0]        r_status;

    logic [EXP_W-1:0]  w_ea, w_eb;
    logic [MAN_W-1:0]  w_ma, w_mb;
    logic              w_sign, w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    logic              w_special;
    logic [31:0]       w_spec_z, w_rnd_z;
    logic [7:0]        w_spec_status, w_rnd_status;
    logic [23:0]       w_r_init, w_d_init;
    logic [9:0]        w_exp_init;
    logic [25:0]       w_t;

    assign w_ea       = r_a[30:23];
    assign w_eb       = r_b[30:23];
    assign w_ma       = r_a[22:0];
    assign w_mb       = r_b[22:0];
    assign w_sign     = r_a[31] ^ r_b[31];
    assign w_a_zero   = (w_ea == 8'd0);
    assign w_b_zero   = (w_eb == 8'd0);
    assign w_a_inf    = (w_ea == 8'hFF) && (w_ma == 23'd0);
    assign w_b_inf    = (w_eb == 8'hFF) && (w_mb == 23'd0);
    assign w_a_nan    = (w_ea == 8'hFF) && (w_ma != 23'd0);
    assign w_b_nan    = (w_eb == 8'hFF) && (w_mb != 23'd0);
    assign w_r_init   = {1'b1, w_ma};
    assign w_d_init   = {1'b1, w_mb};
    assign w_exp_init = {2'b00, w_ea} - {2'b00, w_eb} + 10'(BIAS);
    // The remainder stays below twice the divisor, so bit 25 flags a negative trial
    assign w_t        = r_rem - {2'b00, r_div};

    // Special-operand classification, resolved entirely in SETUP
    always_comb begin
        w_special     = 1'b1;
        w_spec_z      = {w_sign, 31'd0};
        w_spec_status = 8'd0;
        if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
            w_spec_z              = QNAN;
            w_spec_status[ST_NAN] = 1'b1;
        end else if (w_a_inf) begin
            w_spec_z              = {w_sign, 8'hFF, 23'd0};
            w_spec_status[ST_INF] = 1'b1;
        end else if (w_b_zero) begin
            w_spec_z                  = {w_sign, 8'hFF, 23'd0};
            w_spec_status[ST_INF]     = 1'b1;
            w_spec_status[ST_DIVZERO] = 1'b1;
        end else if (w_a_zero || w_b_inf) begin
            w_spec_z               = {w_sign, 31'd0};
            w_spec_status[ST_ZERO] = 1'b1;
        end else begin
            w_special = 1'b0;
        end
    end

    fp_div_round u_round (
        .i_sign   (r_sign),
        .i_exp    (r_exp),
        .i_q      (r_q),
        .i_sticky (r_rem != 26'd0),
        .i_mode   (r_rnd),
        .o_z      (w_rnd_z),
        .o_status (w_rnd_status)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = SETUP; else w_next = IDLE;
            SETUP:   if (w_special) w_next = DONE; else w_next = DIV;
            DIV:     if (r_cnt == 5'd0) w_next = ROUND; else w_next = DIV;
            ROUND:   w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Operand capture, division datapath and registered handshake/result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_rnd    <= 3'd0;
            r_sign   <= 1'b0;
            r_exp    <= 10'sd0;
            r_rem    <= 26'd0;
            r_div    <= 24'd0;
            r_q      <= '0;
            r_cnt    <= 5'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_z      <= 32'd0;
            r_status <= 8'd0;
        end else begin
            r_busy <= (w_next == SETUP) || (w_next == DIV) || (w_next == ROUND);
            r_done <= (w_next == DONE);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_rnd <= rnd;
                    end
                end
                SETUP: begin
                    r_sign <= w_sign;
                    r_div  <= w_d_init;
                    r_q    <= '0;
                    r_cnt  <= CNT_INIT;
                    if (w_special) begin
                        r_z      <= w_spec_z;
                        r_status <= w_spec_status;
                    end else if (w_r_init < w_d_init) begin
                        r_rem <= {1'b0, w_r_init, 1'b0};
                        r_exp <= $signed(w_exp_init - 10'd1);
                    end else begin
                        r_rem <= {2'b00, w_r_init};
                        r_exp <= $signed(w_exp_init);
                    end
                end
                DIV: begin
                    if (!w_t[25]) begin
                        r_q   <= {r_q[QBITS-2:0], 1'b1};
                        r_rem <= {w_t[24:0], 1'b0};
                    end else begin
                        r_q   <= {r_q[QBITS-2:0], 1'b0};
                        r_rem <= {r_rem[24:0], 1'b0};
                    end
                    if (r_cnt != 5'd0) r_cnt <= r_cnt - 5'd1;
                end
                ROUND: begin
                    r_z      <= w_rnd_z;
                    r_status <= w_rnd_status;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign z      = r_z;
    assign status = r_status;

endmodule

// File: doc/fp_div.md
Name: fp_div

Overview:
- Iterative IEEE-754 binary32 divider, z = a / b. It is the inverse-operation companion to the pipelined multiplier and shares its rounding-mode encoding and status-byte layout.
- Radix-2 restoring division produces one quotient bit per cycle. A start/busy/done handshake sits in front of a shared FP datapath.
- Denormal inputs flush to zero. Denormal results flush to zero, or to min-normal under directed rounding.

Parameters:
- EXP_W, 8, exponent width.
- MAN_W, 23, stored mantissa width.
- BIAS, 127, exponent bias.
- QBITS, 25, quotient bits generated: 24 significant plus guard.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle request. Sampled only in IDLE.
- a  in  32  dividend, sampled when start is accepted.
- b  in  32  divisor, sampled when start is accepted.
- rnd  in  3  rounding mode (round_mode_t), sampled when start is accepted.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; z and status are valid in the same cycle.
- z  out  32  result, held until the next accepted start.
- status  out  8  {divzero, 0, inexact, huge, tiny, nan, inf, zero}, held like z.

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, z=0, status=0.
  - Assertion mid-operation aborts the operation. No done is produced.
- States: IDLE -> SETUP -> DIV -> ROUND -> DONE -> IDLE. There is also a special path SETUP -> DONE.
- IDLE: on start=1, latch a, b and rnd, then go to SETUP. start in any other state is ignored.
- SETUP (1 cycle): sign = a[31]^b[31]. Operand class comes from the exponent/mantissa fields; exponent 0 counts as zero.
  - Special cases go straight to DONE:
    - NaN operand, 0/0 or inf/inf: z=0x7FC00000, nan=1.
    - inf/finite: signed inf, inf=1.
    - finite-nonzero/0: signed inf, inf=1, divzero=1.
    - 0/nonzero or finite/inf: signed zero, zero=1.
  - Otherwise:
    - exp = ea - eb + BIAS, 10-bit signed.
    - R = {1,ma}; D = {1,mb}.
    - If R < D, then R <<= 1 and exp -= 1.
    - Set cnt = QBITS-1 and go to DIV.
- DIV (QBITS cycles): each cycle, compute T = R - D.
  - If T >= 0: q = {q,1}, R = T<<1.
  - Else: q = {q,0}, R = R<<1.
  - Leave when cnt = 0; otherwise cnt decrements.
  - The msb of q is always 1.
- ROUND (1 cycle):
  - mant = q[23:1], guard = q[0], sticky = (R != 0), inexact = guard|sticky.
  - Round-up rules:
    - IEEE_near: guard & (sticky | lsb).
    - IEEE_zero: never.
    - IEEE_pinf: inexact & ~sign.
    - IEEE_ninf: inexact & sign.
    - near_up: guard & ~sign, or guard & sticky.
    - away_zero: inexact.
    - Codes 6 and 7 behave as IEEE_near.
  - A mantissa carry-out increments exp and zeroes the mantissa.
  - Overflow (exp >= 255): huge=1, inexact=1.
    - Result is inf (inf=1) for near, near_up and away_zero.
    - Result is max-finite 0x7F7FFFFF (sign applied) for IEEE_zero, and for pinf/ninf when rounding toward zero.
  - Underflow (exp <= 0): tiny=1, inexact=1.
    - Result is signed zero (zero=1).
    - Exception: min-normal 0x00800000 (sign applied) for away_zero, and for pinf/ninf when rounding away from zero.
- DONE (1 cycle): done=1, busy=0. Register z/status, then go to IDLE.
  - A start in this cycle is ignored.
  - A start in the following IDLE cycle is accepted.
- Latency from the start cycle to the done cycle:
  - Normal path: 1+1+QBITS+1 = 28 cycles; done is asserted at edge 28 after the accepting edge.
  - Special path: 2 cycles.
- Throughput: at most one operation per latency + 1 cycles.

Decomposition:
- rounding_pkg: reuse round_mode_t unchanged.
- Add to rounding_pkg:
  - div_state_t {IDLE, SETUP, DIV, ROUND, DONE}.
  - Constants QNAN=32'h7FC00000 and MAXF_MAG=31'h7F7FFFFF.
  - Status bit-index localparams.
- Sub-module fp_div_round (combinational): inputs sign, exp, q and the sticky remainder flag plus mode; outputs z, status. Instantiated once from ROUND.

Test Plan:
- 6.0/2.0: a=40C00000, b=40000000, rnd=IEEE_near -> z=40400000, status=00. done exactly 28 cycles after start, with busy high in between.
- 1.0/3.0: a=3F800000, b=40400000 -> IEEE_near gives z=3EAAAAAB, status=20. The same inputs with IEEE_zero give z=3EAAAAAA, status=20.
- Specials:
  - 1.0/0.0 -> 7F800000, status=82.
  - 0/0 -> 7FC00000, status=04.
  - -0.0/1.0 -> 80000000, status=01.
  - Each completes with done 2 cycles after start.
- Overflow: a=7F000000, b=3E800000 -> IEEE_near gives 7F800000, status=32. IEEE_zero gives 7F7FFFFF, status=30.
- Underflow and handshake:
  - a=00800000, b=40000000, IEEE_near -> 00000000, status=29. IEEE_pinf -> 00800000, status=28.
  - start pulsed during busy is ignored, and the result matches the first operands.
- Reset: assert rst in DIV cycle 10 -> busy, done, z and status are 0 immediately. No done pulse follows. The next start completes normally.
